// File: rtl/core_mem_responder.sv
// Byte-bus responder for the 8088 core: top-of-memory boot ROM plus 16-bit async SRAM with a read buffer.
// Optional CORE_MEM_WORD_PREFETCH_EN: buffer a whole 16-bit word so the sibling byte hits with no stall.
module core_mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ROM_AW      = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_locked,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  // state   | meaning
  // IDLE    | serve hits, detect misses
  // ROM_RD  | BRAM address registered, capture ROM byte(s)
  // SRAM_RD | output enable held, capture lane/word on last cycle
  // SRAM_WR | write strobe held, complete write on last cycle
  typedef enum logic [1:0] {IDLE, ROM_RD, SRAM_RD, SRAM_WR} state_t;

`ifdef CORE_MEM_WORD_PREFETCH_EN
  localparam int BUF_LSB = 1;
  localparam int BUF_W   = 16;
`else
  localparam int BUF_LSB = 0;
  localparam int BUF_W   = 8;
`endif
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_LOAD  = CW'(WAIT_STATES);
  localparam logic [CW-1:0] ROM_LOAD = CW'(BUF_LSB);

  state_t              state, state_nxt;
  logic [19:BUF_LSB]   buf_addr, acc_addr;
  logic [BUF_W-1:0]    buf_data;
  logic                buf_valid;
  logic [19:0]         wr_addr;
  logic [7:0]          wr_data;
  logic                wr_done;
  logic [ROM_AW-1:0]   rom_addr;
  logic [CW-1:0]       cnt;
  logic                in_rom, rd_hit, wr_hit;
  logic                start_rom, start_rd, start_wr, rom_wr, last;

  // Boot image: reset vector at the top 16 bytes is JMP F000:E05B, rest is a fill pattern.
  function automatic logic [7:0] rom_byte(input logic [ROM_AW-1:0] a);
    logic [7:0] d;
    d = a[7:0] ^ 8'h5A;
    if (&a[ROM_AW-1:4]) begin
      case (a[3:0])
        4'h0: d = 8'hEA;
        4'h1: d = 8'h5B;
        4'h2: d = 8'hE0;
        4'h3: d = 8'h00;
        4'h4: d = 8'hF0;
        default: ;
      endcase
    end
    return d;
  endfunction

  assign in_rom = &cpu_address[19:ROM_AW];
  assign rd_hit = buf_valid && (buf_addr == cpu_address[19:BUF_LSB]);
  assign wr_hit = wr_done && (wr_addr == cpu_address) && (wr_data == cpu_out);

`ifdef CORE_MEM_WORD_PREFETCH_EN
  assign cpu_in = cpu_address[0] ? buf_data[15:8] : buf_data[7:0];
`else
  assign cpu_in = buf_data;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_rom = 1'b0;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    rom_wr    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_we) begin
          if (!wr_hit) begin
            if (in_rom) begin
              rom_wr = 1'b1;
            end else begin
              start_wr  = 1'b1;
              state_nxt = SRAM_WR;
            end
          end
        end else if (!rd_hit) begin
          if (in_rom) begin
            start_rom = 1'b1;
            state_nxt = ROM_RD;
          end else begin
            start_rd  = 1'b1;
            state_nxt = SRAM_RD;
          end
        end
      end
      ROM_RD, SRAM_RD, SRAM_WR: begin
        if (cnt == '0) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cpu_locked = !reset && (state == IDLE) && (cpu_we ? wr_hit : rd_hit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_addr   <= '0;
      acc_addr   <= '0;
      buf_data   <= '0;
      buf_valid  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_done    <= 1'b0;
      rom_addr   <= '0;
      cnt        <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;

      if (start_rom) begin
        acc_addr  <= cpu_address[19:BUF_LSB];
        rom_addr  <= cpu_address[ROM_AW-1:0] & ~ROM_AW'(BUF_LSB);
        cnt       <= ROM_LOAD;
        buf_valid <= 1'b0;
        wr_done   <= 1'b0;
      end

      if (start_rd) begin
        acc_addr  <= cpu_address[19:BUF_LSB];
        sram_addr <= cpu_address[19:1];
        sram_oe_n <= 1'b0;
`ifdef CORE_MEM_WORD_PREFETCH_EN
        sram_ub_n <= 1'b0;
        sram_lb_n <= 1'b0;
`else
        sram_ub_n <= !cpu_address[0];
        sram_lb_n <= cpu_address[0];
`endif
        cnt       <= WS_LOAD;
        buf_valid <= 1'b0;
        wr_done   <= 1'b0;
      end

      if (start_wr) begin
        sram_addr  <= cpu_address[19:1];
        sram_dq_o  <= {cpu_out, cpu_out};
        sram_dq_oe <= 1'b1;
        sram_we_n  <= 1'b0;
        sram_ub_n  <= !cpu_address[0];
        sram_lb_n  <= cpu_address[0];
        cnt        <= WS_LOAD;
        wr_done    <= 1'b0;
        wr_addr    <= cpu_address;
        wr_data    <= cpu_out;
        // Keep the read buffer coherent with the SRAM contents.
        if (buf_valid && (buf_addr == cpu_address[19:BUF_LSB])) begin
`ifdef CORE_MEM_WORD_PREFETCH_EN
          if (cpu_address[0]) buf_data[15:8] <= cpu_out;
          else                buf_data[7:0]  <= cpu_out;
`else
          buf_data <= cpu_out;
`endif
        end
      end

      if (rom_wr) begin
        wr_done <= 1'b1;
        wr_addr <= cpu_address;
        wr_data <= cpu_out;
      end

      case (state)
        ROM_RD: begin
`ifdef CORE_MEM_WORD_PREFETCH_EN
          if (rom_addr[0]) buf_data[15:8] <= rom_byte(rom_addr);
          else             buf_data[7:0]  <= rom_byte(rom_addr);
          rom_addr <= rom_addr + 1'b1;
`else
          buf_data <= rom_byte(rom_addr);
`endif
          if (last) begin
            buf_valid <= 1'b1;
            buf_addr  <= acc_addr;
          end
        end
        SRAM_RD: begin
          if (last) begin
`ifdef CORE_MEM_WORD_PREFETCH_EN
            buf_data <= sram_dq_i;
`else
            buf_data <= acc_addr[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
`endif
            buf_valid <= 1'b1;
            buf_addr  <= acc_addr;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
          end
        end
        SRAM_WR: begin
          if (last) begin
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            wr_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: directed boot/SRAM cases, then random traffic checked
// against a transaction-level model of buffer hits, stall lengths, strobe pulses and memory contents.
module tb_core_mem_responder;
  localparam int WS = 2;
`ifdef CORE_MEM_WORD_PREFETCH_EN
  localparam bit WORD = 1'b1;
`else
  localparam bit WORD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_out = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_in;
  logic        cpu_locked;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  core_mem_responder #(.WAIT_STATES(WS), .ROM_AW(12)) dut (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_in(cpu_in), .cpu_locked(cpu_locked), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n));

  always #5 clock = ~clock;

  // Board SRAM: 256 words is enough for the address window used here.
  logic [15:0] sram_arr [0:255];
  assign sram_dq_i = sram_oe_n ? 16'hDEAD : sram_arr[sram_addr[7:0]];
  always @(posedge clock) begin
    if (!sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) sram_arr[sram_addr[7:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_ub_n) sram_arr[sram_addr[7:0]][15:8] = sram_dq_o[15:8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory image plus last-read / last-write bookkeeping.
  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [7:0]  data;
    int          stall;
    int          oe_cyc;
    int          we_cyc;
  } exp_t;
  exp_t q[$];

  logic [7:0]  ref_mem [0:511];
  bit          m_bv = 0, m_wd = 0;
  logic [19:0] m_ba = '0, m_wa = '0;
  logic [7:0]  m_wdat = '0;

  function automatic logic [7:0] rom_img(input logic [19:0] a);
    logic [7:0] vec [0:4];
    vec = '{8'hEA, 8'h5B, 8'hE0, 8'h00, 8'hF0};
    if (a[11:4] == 8'hFF && a[3:0] <= 4'h4) return vec[a[3:0]];
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic issue(input logic [19:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    bit rom, hit;
    rom = (a[19:12] == 8'hFF);
    e.we = w; e.addr = a; e.data = d; e.oe_cyc = 0; e.we_cyc = 0;
    if (!w) begin
      hit = m_bv && (WORD ? (m_ba[19:1] == a[19:1]) : (m_ba == a));
      e.stall  = hit ? 0 : (rom ? (WORD ? 3 : 2) : WS + 2);
      e.oe_cyc = (hit || rom) ? 0 : WS + 1;
      e.data   = rom ? rom_img(a) : ref_mem[a[8:0]];
      if (!hit) begin m_bv = 1; m_ba = a; m_wd = 0; end
    end else begin
      hit = m_wd && (m_wa == a) && (m_wdat == d);
      e.stall  = hit ? 0 : (rom ? 1 : WS + 2);
      e.we_cyc = (hit || rom) ? 0 : WS + 1;
      if (!hit && !rom) ref_mem[a[8:0]] = d;
      m_wd = 1; m_wa = a; m_wdat = d;
    end
    q.push_back(e);
  endtask

  // Monitor: checks pins during stalls and retires one expectation per completed cycle.
  bit mon_en = 0;
  int stall_c = 0, oe_c = 0, we_c = 0;
  always @(negedge clock) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) we_c++;
      if (!sram_oe_n || !sram_we_n) begin
        if (q.size() == 0) chk("strobe_without_txn", 1, 0);
        else begin
          e = q[0];
          chk("strobe_addr", sram_addr, e.addr[19:1]);
          if (!e.we) begin
            chk("rd_we_n", sram_we_n, 1);
            chk("rd_dq_oe", sram_dq_oe, 0);
            chk("rd_ub_n", sram_ub_n, WORD ? 1'b0 : !e.addr[0]);
            chk("rd_lb_n", sram_lb_n, WORD ? 1'b0 : e.addr[0]);
          end else begin
            chk("wr_oe_n", sram_oe_n, 1);
            chk("wr_dq_oe", sram_dq_oe, 1);
            chk("wr_dq_o", sram_dq_o, {e.data, e.data});
            chk("wr_ub_n", sram_ub_n, !e.addr[0]);
            chk("wr_lb_n", sram_lb_n, e.addr[0]);
          end
        end
      end
      if (!cpu_locked) stall_c++;
      else if (q.size() == 0) chk("unexpected_complete", 1, 0);
      else begin
        e = q.pop_front();
        chk(e.we ? "wr_stall" : "rd_stall", stall_c, e.stall);
        chk("oe_cycles", oe_c, e.oe_cyc);
        chk("we_cycles", we_c, e.we_cyc);
        if (!e.we) chk("rd_data", cpu_in, e.data);
        stall_c = 0; oe_c = 0; we_c = 0;
      end
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Called at posedge+1; holds the request until the responder unlocks, then advances one edge.
  task automatic txn(input logic [19:0] a, input logic w, input logic [7:0] d);
    int n;
    cpu_address = a; cpu_we = w; cpu_out = d;
    issue(a, w, d);
    n = 0;
    @(negedge clock);
    while (!cpu_locked) begin
      n++;
      if (n > 40) begin
        errors++; checks++;
        $display("FAIL timeout: addr=%05h still locked after %0d cycles, required <= %0d", a, n, WS + 3);
        finish_run();
      end
      @(negedge clock);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [15:0] w;
    logic [19:0] a, pa;
    logic [7:0]  d, pd;
    logic        we, pwe;
    int          n, oc;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (i == 8'h80) w = 16'h3412;
      sram_arr[i] = w;
      ref_mem[2*i] = w[7:0];
      ref_mem[2*i+1] = w[15:8];
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_locked", cpu_locked, 0);
    chk("rst_cpu_in", cpu_in, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'hF);
    chk("rst_dq_oe", sram_dq_oe, 0);

    @(posedge clock); #1;
    reset = 0;
    mon_en = 1;
    txn(20'hFFFF0, 0, 8'h00);
    txn(20'h00100, 0, 8'h00);
    txn(20'h00100, 0, 8'h00);
    txn(20'h00167, 1, 8'h55);
    txn(20'h00167, 1, 8'h55);
    txn(20'h00167, 0, 8'h00);
    txn(20'hFF000, 1, 8'hAA);
    txn(20'hFF000, 0, 8'h00);
    txn(20'h00100, 0, 8'h00);
    txn(20'h00101, 0, 8'h00);

    pa = 20'h00101; pwe = 0; pd = 0;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 9);
      we = ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      if (n < 2) begin
        a = pa; we = pwe; d = pd;
      end else if (n < 4) begin
        a = pa ^ 20'h1;
      end else if (n < 6) begin
        a = (n == 4) ? (20'hFFFF0 + 20'($urandom_range(0, 4))) : (20'hFF000 | 20'($urandom_range(0, 4095)));
      end else begin
        a = 20'($urandom_range(0, 511));
      end
      txn(a, we, d);
      pa = a; pwe = we; pd = d;
    end

    @(negedge clock);
    chk("queue_drained", q.size(), 0);

    // Reset landing on the second SRAM read cycle must abort the access cleanly.
    mon_en = 0;
    cpu_we = 0;
    a = 20'h00042;
    if (m_bv && m_ba[19:1] == a[19:1]) a = 20'h001F0;
    cpu_address = a;
    @(posedge clock); #1;
    chk("rstmid_oe_active", sram_oe_n, 0);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    chk("rstmid_oe_n", sram_oe_n, 1);
    chk("rstmid_lanes", {sram_ub_n, sram_lb_n}, 2'b11);
    chk("rstmid_locked_in_reset", cpu_locked, 0);
    reset = 0;
    m_bv = 0; m_wd = 0;
    n = 0; oc = 0;
    @(negedge clock);
    while (!cpu_locked && n <= 40) begin
      n++;
      if (!sram_oe_n) oc++;
      @(negedge clock);
    end
    chk("rstmid_reissue_stall", n, WS + 2);
    chk("rstmid_reissue_oe", oc, WS + 1);
    chk("rstmid_reissue_data", cpu_in, ref_mem[a[8:0]]);

    finish_run();
  end
endmodule
